mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified-memory signals around mem_port_arbiter.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface mem_port_arbiter_if;
    // Fetch (F stage) request
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;

    // Load/store (M stage) request
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    // Unified memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Pipeline control / status
    logic        stall;
    logic        mem_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output if_rdata, dm_rdata,
        output stall, mem_err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  if_rdata, dm_rdata,
        input  stall, mem_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory port between instruction fetch and load/store.
// Data accesses win over fetches (the M-stage instruction is older). Each requester
// is served at most once per pipeline advance; the pipeline is stalled until every
// active requester has its result. Back-to-back accesses issue with no idle cycle.
//
// Optional build macro MEM_TIMEOUT_EN: adds an 8-bit wait counter; an access that
// waits 255 cycles without mem_ready completes with read data 0 and sets the
// sticky mem_err flag. Without it, accesses wait indefinitely and mem_err is 0.
module mem_port_arbiter (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StData
    } state_e;

    state_e      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_got_q, if_got_d;
    logic        dm_got_q, dm_got_d;

    logic        busy;
    logic        timeout_hit;
    logic        done;
    logic        fetch_done;
    logic        data_done;
    logic [31:0] rdata_eff;
    logic        if_ok;
    logic        dm_ok;
    logic        if_want;
    logic        dm_want;
    logic        stall;
    logic        grant_data;
    logic        grant_fetch;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;

    // A stuck access gives up once the counter has saturated.
    assign timeout_hit = busy && !bus.mem_ready && (wait_cnt_q == 8'hFF);
`else
    assign timeout_hit = 1'b0;
`endif

    // Completion of the outstanding access and which requester it belongs to.
    assign busy       = (state_q == StFetch) || (state_q == StData);
    assign done       = busy && (bus.mem_ready || timeout_hit);
    assign fetch_done = done && (state_q == StFetch);
    assign data_done  = done && (state_q == StData);
    assign rdata_eff  = timeout_hit ? 32'h0 : bus.mem_rdata;

    // A requester is satisfied if served earlier in this stall or completing now.
    assign if_ok   = if_got_q || fetch_done;
    assign dm_ok   = dm_got_q || data_done;
    assign if_want = bus.if_req && !if_ok;
    assign dm_want = bus.dm_req && !dm_ok;
    assign stall   = if_want || dm_want;

    // Grant selection: only from idle or on the completion edge, data first.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if ((state_q == StIdle) || done) begin
            if (dm_want) begin
                grant_data = 1'b1;
            end else if (if_want) begin
                grant_fetch = 1'b1;
            end
        end
    end

    // Next state and registered memory request, held stable until completion.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant_data) begin
            state_d     = StData;
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
        end else if (grant_fetch) begin
            state_d     = StFetch;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = 32'h0;
        end else if (done) begin
            state_d = StIdle;
        end
    end

    // Result capture and served flags; flags drop when the pipeline advances.
    always_comb begin
        if_rdata_d = fetch_done ? rdata_eff : if_rdata_q;
        // Stores leave the load-data register untouched.
        dm_rdata_d = (data_done && !mem_we_q) ? rdata_eff : dm_rdata_q;
        if_got_d   = 1'b0;
        dm_got_d   = 1'b0;
        if (stall) begin
            // A result for a withdrawn request is not recorded as served.
            if_got_d = if_got_q || (fetch_done && bus.if_req);
            dm_got_d = dm_got_q || (data_done && bus.dm_req);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            if_got_q    <= 1'b0;
            dm_got_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_got_q    <= if_got_d;
            dm_got_q    <= dm_got_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait counter: restarts on every grant, counts un-ready cycles while busy.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_data || grant_fetch) begin
            wait_cnt_d = 8'h0;
        end else if (busy && !bus.mem_ready && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        mem_err_d = mem_err_q || timeout_hit;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 8'h0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign bus.mem_err = mem_err_q;
`else
    assign bus.mem_err = 1'b0;
`endif

    assign bus.mem_req   = busy;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    // Results are visible in their completion cycle, then held by the registers.
    assign bus.if_rdata  = if_rdata_d;
    assign bus.dm_rdata  = dm_rdata_d;
    assign bus.stall     = stall;

endmodule
